// File: rtl/jk_bank_driver_if.sv
// Command handshake bundle for jk_bank_driver.
//   cmd_valid  : a command is present (master -> slave)
//   cmd_ready  : the driver can accept a command this cycle (slave -> master)
//   cmd_op     : 0 HOLD, 1 SET, 2 CLR, 3 TOGGLE, 4 LOAD, 5 CNT_UP, 6 CNT_DN, 7 illegal
//   cmd_mask   : bits affected by SET/CLR/TOGGLE/LOAD
//   cmd_data   : load value for LOAD
interface jk_bank_driver_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_mask,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_mask,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/jk_bank_driver.sv
// Command-driven controller for a bank of WIDTH JK flip-flops.
// Each accepted command becomes one cycle of J/K excitation; the driver keeps
// its own model of the bank contents (exp_q) and compares it with the fed-back
// Q two edges after acceptance. After reset it clears the bank itself, since
// the flip-flops' Q is not touched by reset.
//
// Ports:
//   clk        : rising-edge clock shared with the bank
//   reset      : synchronous, active-high, shared with the bank
//   cmd        : command handshake (slave side of jk_bank_driver_if)
//   q_fb       : Q outputs of the bank
//   J, K       : registered J/K inputs of the bank
//   exp_q      : modelled bank state
//   done       : one-cycle pulse at command completion
//   err        : one-cycle pulse with done (mismatch or illegal op), or at the
//                post-reset check on a mismatch
//   err_bits   : q_fb ^ exp_q captured at the check, valid while err is high
//   err_sticky : set by any err, cleared only by reset
module jk_bank_driver #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    jk_bank_driver_if.slave    cmd,
    input  logic [WIDTH-1:0]   q_fb,
    output logic [WIDTH-1:0]   J,
    output logic [WIDTH-1:0]   K,
    output logic [WIDTH-1:0]   exp_q,
    output logic               done,
    output logic               err,
    output logic [WIDTH-1:0]   err_bits,
    output logic               err_sticky
);

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_SET    = 3'd1;
    localparam logic [2:0] OP_CLR    = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_CNT_UP = 3'd5;
    localparam logic [2:0] OP_CNT_DN = 3'd6;

    typedef enum logic [2:0] {
        S_INIT,
        S_INIT_CHK,
        S_IDLE,
        S_DRIVE,
        S_CHECK
    } state_t;

    state_t state, state_nxt;

    logic             ready_q;
    logic             chk_arm;      // INIT_CHK: 0 while the bank samples the clear, 1 on the compare edge
    logic             illegal_q;    // the command in flight was op 7

    logic [WIDTH-1:0] j_nxt, k_nxt, exp_nxt, err_bits_nxt;
    logic             done_nxt, err_nxt, sticky_nxt, ready_nxt, arm_nxt, illegal_nxt;
    logic [WIDTH-1:0] diff;
    logic             accept;

    // Bits that flip when counting up: bit i toggles when all lower bits are 1.
    function automatic logic [WIDTH-1:0] up_toggles(input logic [WIDTH-1:0] e);
        logic [WIDTH-1:0] t;
        t    = '0;
        t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & e[i-1];
        end
        return t;
    endfunction

    // Bits that flip when counting down: bit i toggles when all lower bits are 0.
    function automatic logic [WIDTH-1:0] dn_toggles(input logic [WIDTH-1:0] e);
        logic [WIDTH-1:0] t;
        t    = '0;
        t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & ~e[i-1];
        end
        return t;
    endfunction

    assign cmd.cmd_ready = ready_q;
    assign accept        = (state == S_IDLE) && cmd.cmd_valid && ready_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:     state_nxt = S_INIT_CHK;
            S_INIT_CHK: state_nxt = chk_arm ? S_IDLE : S_INIT_CHK;
            S_IDLE:     state_nxt = accept ? S_DRIVE : S_IDLE;
            S_DRIVE:    state_nxt = S_CHECK;
            S_CHECK:    state_nxt = S_IDLE;
            default:    state_nxt = S_INIT;
        endcase
    end

    // Output logic: values the output registers take at the coming edge.
    always_comb begin
        j_nxt        = '0;
        k_nxt        = '0;
        exp_nxt      = exp_q;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        err_bits_nxt = '0;
        sticky_nxt   = err_sticky;
        ready_nxt    = (state_nxt == S_IDLE);
        arm_nxt      = 1'b0;
        illegal_nxt  = illegal_q;
        diff         = q_fb ^ exp_q;

        case (state)
            S_INIT: begin
                // Drive every K high for one cycle to clear the bank.
                k_nxt   = '1;
                exp_nxt = '0;
            end
            S_INIT_CHK: begin
                arm_nxt = ~chk_arm;
                if (chk_arm && (|q_fb)) begin
                    err_nxt      = 1'b1;
                    err_bits_nxt = q_fb;
                    sticky_nxt   = 1'b1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    illegal_nxt = (cmd.cmd_op == 3'd7);
                    case (cmd.cmd_op)
                        OP_HOLD: begin
                            j_nxt = '0;
                            k_nxt = '0;
                        end
                        OP_SET: begin
                            j_nxt   = cmd.cmd_mask;
                            exp_nxt = exp_q | cmd.cmd_mask;
                        end
                        OP_CLR: begin
                            k_nxt   = cmd.cmd_mask;
                            exp_nxt = exp_q & ~cmd.cmd_mask;
                        end
                        OP_TOGGLE: begin
                            j_nxt   = cmd.cmd_mask;
                            k_nxt   = cmd.cmd_mask;
                            exp_nxt = exp_q ^ cmd.cmd_mask;
                        end
                        OP_LOAD: begin
                            j_nxt   = cmd.cmd_mask & cmd.cmd_data;
                            k_nxt   = cmd.cmd_mask & ~cmd.cmd_data;
                            exp_nxt = (exp_q & ~cmd.cmd_mask) | (cmd.cmd_mask & cmd.cmd_data);
                        end
                        OP_CNT_UP: begin
                            j_nxt   = up_toggles(exp_q);
                            k_nxt   = j_nxt;
                            exp_nxt = exp_q ^ j_nxt;
                        end
                        OP_CNT_DN: begin
                            j_nxt   = dn_toggles(exp_q);
                            k_nxt   = j_nxt;
                            exp_nxt = exp_q ^ j_nxt;
                        end
                        default: begin
                            j_nxt = '0;
                            k_nxt = '0;
                        end
                    endcase
                end
            end
            S_CHECK: begin
                done_nxt = 1'b1;
                if ((|diff) || illegal_q) begin
                    err_nxt      = 1'b1;
                    err_bits_nxt = diff;
                    sticky_nxt   = 1'b1;
                end
            end
            default: begin
                j_nxt = '0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            J          <= '0;
            K          <= '0;
            exp_q      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_bits   <= '0;
            err_sticky <= 1'b0;
            ready_q    <= 1'b0;
            chk_arm    <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            J          <= j_nxt;
            K          <= k_nxt;
            exp_q      <= exp_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            err_bits   <= err_bits_nxt;
            err_sticky <= sticky_nxt;
            ready_q    <= ready_nxt;
            chk_arm    <= arm_nxt;
            illegal_q  <= illegal_nxt;
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: attaches a behavioural JK bank (with an optional
// stuck-at-0 fault on its Q outputs) and checks every cycle of each command
// against a model of what the bank should contain.
module tb_jk_bank_driver;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] q_fb;
    logic [W-1:0] J, K, exp_q, err_bits;
    logic         done, err, err_sticky;

    logic [W-1:0] bank_q = 4'b1101;   // Q is not reset, so start from garbage
    logic [W-1:0] stuck;              // bits of q_fb forced to 0

    logic [W-1:0] e_mdl;
    logic         sticky_mdl;
    int           vectors;
    int           miscompares;

    jk_bank_driver_if #(.WIDTH(W)) cmd_if ();

    jk_bank_driver #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd_if),
        .q_fb       (q_fb),
        .J          (J),
        .K          (K),
        .exp_q      (exp_q),
        .done       (done),
        .err        (err),
        .err_bits   (err_bits),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // JK bank: J&K toggles, J sets, K clears, neither holds.
    always @(posedge clk) bank_q <= (J & ~bank_q) | (~K & bank_q);
    assign q_fb = bank_q & ~stuck;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_v(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Three edges after reset release: drive K=all ones, let the bank clear, compare.
    task automatic init_seq();
        step();
        check_v("init1_j", J, '0);
        check_v("init1_k", K, '1);
        check_v("init1_expq", exp_q, '0);
        check_b("init1_rdy", cmd_if.cmd_ready, 1'b0);
        check_b("init1_done", done, 1'b0);
        step();
        check_v("init2_j", J, '0);
        check_v("init2_k", K, '0);
        check_b("init2_rdy", cmd_if.cmd_ready, 1'b0);
        check_b("init2_done", done, 1'b0);
        step();
        check_b("init3_rdy", cmd_if.cmd_ready, 1'b1);
        check_b("init3_err", err, 1'b0);
        check_b("init3_done", done, 1'b0);
        check_v("init3_expq", exp_q, '0);
        check_v("init3_qfb", q_fb, '0);
        e_mdl = '0;
    endtask

    // Issue one command from IDLE and check it through completion.
    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] m, input logic [W-1:0] d,
                          input bit hold_valid);
        logic [W-1:0] jx, kx, en, dx;
        logic         errx;
        case (op)
            3'd1: begin jx = m;      kx = '0;      en = e_mdl | m; end
            3'd2: begin jx = '0;     kx = m;       en = e_mdl & ~m; end
            3'd3: begin jx = m;      kx = m;       en = e_mdl ^ m; end
            3'd4: begin jx = m & d;  kx = m & ~d;  en = (e_mdl & ~m) | (m & d); end
            3'd5: begin en = e_mdl + 4'd1; jx = e_mdl ^ en; kx = jx; end
            3'd6: begin en = e_mdl - 4'd1; jx = e_mdl ^ en; kx = jx; end
            default: begin jx = '0;  kx = '0;      en = e_mdl; end
        endcase

        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_mask  = m;
        cmd_if.cmd_data  = d;
        step();                                    // E0: accept
        check_v("e0_j", J, jx);
        check_v("e0_k", K, kx);
        check_v("e0_expq", exp_q, en);
        check_b("e0_rdy", cmd_if.cmd_ready, 1'b0);
        check_b("e0_done", done, 1'b0);
        if (!hold_valid) cmd_if.cmd_valid = 1'b0;
        step();                                    // E1: bank samples J/K
        check_v("e1_j", J, '0);
        check_v("e1_k", K, '0);
        check_v("e1_expq", exp_q, en);
        check_b("e1_rdy", cmd_if.cmd_ready, 1'b0);
        check_b("e1_done", done, 1'b0);
        step();                                    // E2: compare
        dx   = en & stuck;
        errx = (op == 3'd7) || (dx != '0);
        if (errx) sticky_mdl = 1'b1;
        check_b("e2_done", done, 1'b1);
        check_b("e2_err", err, errx);
        if (errx) check_v("e2_errbits", err_bits, dx);
        check_b("e2_sticky", err_sticky, sticky_mdl);
        check_b("e2_rdy", cmd_if.cmd_ready, 1'b1);
        check_v("e2_expq", exp_q, en);
        check_v("e2_j", J, '0);
        cmd_if.cmd_valid = 1'b0;
        e_mdl = en;
        step();                                    // E3: pulses end, still idle
        check_b("e3_done", done, 1'b0);
        check_b("e3_err", err, 1'b0);
        check_b("e3_rdy", cmd_if.cmd_ready, 1'b1);
        check_v("e3_expq", exp_q, e_mdl);
        check_b("e3_sticky", err_sticky, sticky_mdl);
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        reset            = 1'b1;
        stuck            = '0;
        e_mdl            = '0;
        sticky_mdl       = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_mask  = '0;
        cmd_if.cmd_data  = '0;

        step();
        step();
        check_v("rst_j", J, '0);
        check_v("rst_k", K, '0);
        check_v("rst_expq", exp_q, '0);
        check_b("rst_done", done, 1'b0);
        check_b("rst_err", err, 1'b0);
        check_v("rst_errbits", err_bits, '0);
        check_b("rst_sticky", err_sticky, 1'b0);
        check_b("rst_rdy", cmd_if.cmd_ready, 1'b0);

        reset = 1'b0;
        init_seq();

        do_cmd(3'd4, 4'b1111, 4'b1010, 1'b0);      // LOAD -> 1010
        check_v("load_qfb", q_fb, 4'b1010);
        do_cmd(3'd3, 4'b0011, 4'b0000, 1'b0);      // TOGGLE -> 1001
        do_cmd(3'd4, 4'b1111, 4'b1111, 1'b0);      // LOAD -> 1111
        do_cmd(3'd5, 4'b0000, 4'b0000, 1'b0);      // CNT_UP wraps to 0000
        do_cmd(3'd6, 4'b0000, 4'b0000, 1'b0);      // CNT_DN wraps to 1111
        do_cmd(3'd5, 4'b0000, 4'b0000, 1'b0);      // back to 0000
        do_cmd(3'd5, 4'b0000, 4'b0000, 1'b0);      // 0001, partial carry chain
        do_cmd(3'd2, 4'b1111, 4'b0000, 1'b0);      // CLR all

        stuck = 4'b0100;                           // q_fb[2] stuck at 0
        do_cmd(3'd1, 4'b0100, 4'b0000, 1'b0);      // SET -> mismatch on bit 2
        stuck = '0;
        do_cmd(3'd0, 4'b1111, 4'b1111, 1'b0);      // HOLD, sticky stays up

        do_cmd(3'd7, 4'b1111, 4'b1111, 1'b1);      // illegal, valid held through DRIVE/CHECK

        // Reset while a SET is in DRIVE: command dropped, init repeats.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'd1;
        cmd_if.cmd_mask  = 4'b1111;
        cmd_if.cmd_data  = 4'b0000;
        step();
        check_v("rd_e0_j", J, 4'b1111);
        cmd_if.cmd_valid = 1'b0;
        reset = 1'b1;
        step();
        check_v("rd_j", J, '0);
        check_v("rd_k", K, '0);
        check_b("rd_done", done, 1'b0);
        check_v("rd_expq", exp_q, '0);
        check_b("rd_rdy", cmd_if.cmd_ready, 1'b0);
        check_b("rd_sticky", err_sticky, 1'b0);
        step();
        check_b("rd_done2", done, 1'b0);
        reset      = 1'b0;
        sticky_mdl = 1'b0;
        init_seq();

        for (int i = 0; i < 40; i++) begin
            do_cmd(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
                   1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
